// File: rtl/complex_csd2bin_pipe.sv
// Pipelined complex CSD to two's complement converter with valid/ready backpressure.
// Each axis computes P + ~N + 1, with the carry chain split into STAGES chunks.
module complex_csd2bin_pipe #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       c_x,
    input  logic [2*W-1:0]   s_x,
    input  logic [1:0]       c_y,
    input  logic [2*W-1:0]   s_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W+1:0]     y_x,
    output logic [W+1:0]     y_y,
    output logic             ovf_x,
    output logic             ovf_y
);

    localparam int WT = W + 2;
    localparam int CW = (WT + STAGES - 1) / STAGES;
    localparam int WP = CW * STAGES;

    logic          adv;

    logic [WP-1:0] pDec [2];
    logic [WT-1:0] nRaw [2];
    logic [WP-1:0] nDec [2];

    logic          vIn  [STAGES];
    logic [WP-1:0] pIn  [2][STAGES];
    logic [WP-1:0] nIn  [2][STAGES];
    logic [WP-1:0] sIn  [2][STAGES];
    logic          cIn  [2][STAGES];

    logic          valid_d [STAGES];
    logic          valid_q [STAGES];
    logic [WP-1:0] p_d     [2][STAGES];
    logic [WP-1:0] p_q     [2][STAGES];
    logic [WP-1:0] n_d     [2][STAGES];
    logic [WP-1:0] n_q     [2][STAGES];
    logic [WP-1:0] sum_d   [2][STAGES];
    logic [WP-1:0] sum_q   [2][STAGES];
    logic          cy_d    [2][STAGES];
    logic          cy_q    [2][STAGES];
    logic          ovf_d   [2];
    logic          ovf_q   [2];

    // Split each digit into its positive and negative bit; the carry digit sits at weight 2^W.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            pDec[a] = '0;
            nRaw[a] = '0;
        end
        for (int i = 0; i < W; i++) begin
            pDec[0][i] = s_x[2*i+1];
            nRaw[0][i] = s_x[2*i];
            pDec[1][i] = s_y[2*i+1];
            nRaw[1][i] = s_y[2*i];
        end
        pDec[0][W] = c_x[1];
        nRaw[0][W] = c_x[0];
        pDec[1][W] = c_y[1];
        nRaw[1][W] = c_y[0];
    end

    // N is inverted across the full W+2 result width; padding bits above stay zero.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            nDec[a]         = '0;
            nDec[a][WT-1:0] = ~nRaw[a];
        end
    end

    always_comb begin
        vIn[0] = in_valid;
        for (int a = 0; a < 2; a++) begin
            pIn[a][0] = pDec[a];
            nIn[a][0] = nDec[a];
            sIn[a][0] = '0;
            cIn[a][0] = 1'b1;
        end
        for (int k = 1; k < STAGES; k++) begin
            vIn[k] = valid_q[k-1];
            for (int a = 0; a < 2; a++) begin
                pIn[a][k] = p_q[a][k-1];
                nIn[a][k] = n_q[a][k-1];
                sIn[a][k] = sum_q[a][k-1];
                cIn[a][k] = cy_q[a][k-1];
            end
        end
    end

    // Stage k resolves result bits [k*CW +: CW] and hands its carry-out to stage k+1.
    always_comb begin
        logic [CW:0] part;
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = vIn[k];
            for (int a = 0; a < 2; a++) begin
                part = {1'b0, pIn[a][k][k*CW +: CW]}
                     + {1'b0, nIn[a][k][k*CW +: CW]}
                     + {{CW{1'b0}}, cIn[a][k]};
                p_d[a][k]                 = pIn[a][k];
                n_d[a][k]                 = nIn[a][k];
                sum_d[a][k]               = sIn[a][k];
                sum_d[a][k][k*CW +: CW]   = part[CW-1:0];
                cy_d[a][k]                = part[CW];
            end
        end
    end

    always_comb begin
        for (int a = 0; a < 2; a++) begin
            ovf_d[a] = sum_d[a][STAGES-1][WT-1] ^ sum_d[a][STAGES-1][WT-2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                for (int a = 0; a < 2; a++) begin
                    p_q[a][k]   <= '0;
                    n_q[a][k]   <= '0;
                    sum_q[a][k] <= '0;
                    cy_q[a][k]  <= 1'b0;
                end
            end
            for (int a = 0; a < 2; a++) begin
                ovf_q[a] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                for (int a = 0; a < 2; a++) begin
                    p_q[a][k]   <= p_d[a][k];
                    n_q[a][k]   <= n_d[a][k];
                    sum_q[a][k] <= sum_d[a][k];
                    cy_q[a][k]  <= cy_d[a][k];
                end
            end
            for (int a = 0; a < 2; a++) begin
                ovf_q[a] <= ovf_d[a];
            end
        end
    end

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign out_valid = valid_q[STAGES-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv & ~rst;
    assign y_x       = sum_q[0][STAGES-1][WT-1:0];
    assign y_y       = sum_q[1][STAGES-1][WT-1:0];
    assign ovf_x     = ovf_q[0];
    assign ovf_y     = ovf_q[1];

endmodule

// File: tb/tb_complex_csd2bin_pipe.sv
// Self-checking bench for complex_csd2bin_pipe: directed cases, streaming with stalls,
// reset flush and a full code sweep against a digit-sum reference model.
module tb_complex_csd2bin_pipe;

    localparam int W      = 4;
    localparam int STAGES = 2;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [1:0] c_x       = '0;
    logic [7:0] s_x       = '0;
    logic [1:0] c_y       = '0;
    logic [7:0] s_y       = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] y_x;
    logic [5:0] y_y;
    logic       ovf_x;
    logic       ovf_y;

    int          vectors     = 0;
    int          miscompares = 0;
    int          recvCount   = 0;
    logic [13:0] sbQ[$];
    logic        holdPending = 1'b0;
    logic [13:0] holdVal     = '0;

    complex_csd2bin_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_x       (c_x),
        .s_x       (s_x),
        .c_y       (c_y),
        .s_y       (s_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_x       (y_x),
        .y_y       (y_y),
        .ovf_x     (ovf_x),
        .ovf_y     (ovf_y)
    );

    always #5 clk = ~clk;

    // Integer value of a CSD operand: sum of (p-n)*2^i plus the carry digit at 2^W.
    function automatic int csdVal(input logic [1:0] c, input logic [7:0] s);
        int v;
        v = 0;
        for (int i = 0; i < W; i++) begin
            v += (int'(s[2*i+1]) - int'(s[2*i])) * (1 << i);
        end
        v += (int'(c[1]) - int'(c[0])) * (1 << W);
        return v;
    endfunction

    function automatic logic [13:0] refModel(input logic [1:0] cx, input logic [7:0] sx,
                                             input logic [1:0] cy, input logic [7:0] sy);
        int          vx;
        int          vy;
        logic [31:0] ux;
        logic [31:0] uy;
        logic        ox;
        logic        oy;
        vx = csdVal(cx, sx);
        vy = csdVal(cy, sy);
        ux = vx;
        uy = vy;
        ox = (vx > 15) || (vx < -16);
        oy = (vy > 15) || (vy < -16);
        return {ux[5:0], uy[5:0], ox, oy};
    endfunction

    // One handshake cycle, entered and left at a falling edge.
    task automatic cycle(output bit accepted);
        logic [13:0] act;
        logic [13:0] exp;
        #1;
        act = {y_x, y_y, ovf_x, ovf_y};
        if (holdPending) begin
            vectors++;
            if (out_valid !== 1'b1 || act !== holdVal) begin
                miscompares++;
                $display("[TB] FAIL stall_hold: got valid=%b out=%h, expected valid=1 out=%h",
                         out_valid, act, holdVal);
            end
        end
        if (out_valid && !out_ready) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL in_ready_full: got %b, expected 0", in_ready);
            end
        end
        holdPending = out_valid && !out_ready;
        holdVal     = act;
        if (out_valid && out_ready) begin
            vectors++;
            recvCount++;
            if (sbQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL spurious_output: got out=%h, expected no output", act);
            end else begin
                exp = sbQ.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL result: got y_x=%b y_y=%b ovf=%b%b, expected y_x=%b y_y=%b ovf=%b%b",
                             act[13:8], act[7:2], act[1], act[0],
                             exp[13:8], exp[7:2], exp[1], exp[0]);
                end
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            sbQ.push_back(refModel(c_x, s_x, c_y, s_y));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({out_valid, y_x, y_y, ovf_x, ovf_y} !== 15'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", {out_valid, y_x, y_y, ovf_x, ovf_y});
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL in_ready_after_reset: got %b, expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_and_check(input string name, input logic [1:0] cx, input logic [7:0] sx,
                                  input logic [1:0] cy, input logic [7:0] sy, input logic [13:0] expOut);
        c_x       = cx;
        s_x       = sx;
        c_y       = cy;
        s_y       = sy;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_accept: got in_ready=%b, expected 1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_latency: got out_valid=%b after 1 cycle, expected 0", name, out_valid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({out_valid, y_x, y_y, ovf_x, ovf_y} !== {1'b1, expOut}) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid=%b y_x=%b y_y=%b ovf=%b%b, expected valid=1 y_x=%b y_y=%b ovf=%b%b",
                     name, out_valid, y_x, y_y, ovf_x, ovf_y,
                     expOut[13:8], expOut[7:2], expOut[1], expOut[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        send_and_check("positive_digits", 2'b00, 8'b10101010, 2'b00, 8'b10000001,
                       {6'b001111, 6'b000111, 1'b0, 1'b0});
        send_and_check("carry_overflow", 2'b10, 8'b00000000, 2'b01, 8'b01010101,
                       {6'b010000, 6'b100001, 1'b1, 1'b1});
        send_and_check("all_ones_digits", 2'b11, 8'b11111111, 2'b11, 8'b11111111,
                       {6'b000000, 6'b000000, 1'b0, 1'b0});
    endtask

    task automatic test_stream();
        int         sent;
        bit         acc;
        logic [7:0] enc;
        logic [2:0] v;
        sent        = 0;
        recvCount   = 0;
        holdPending = 1'b0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || sbQ.size() > 0 || out_valid); cyc++) begin
            v   = 3'(sent);
            enc = '0;
            for (int i = 0; i < 3; i++) begin
                enc[2*i+1] = v[i];
            end
            in_valid  = (sent < 8);
            c_x       = 2'b00;
            s_x       = enc;
            c_y       = 2'($urandom_range(0, 3));
            s_y       = 8'($urandom_range(0, 255));
            out_ready = !(cyc >= 3 && cyc <= 5);
            cycle(acc);
            if (acc) sent++;
        end
        in_valid    = 1'b0;
        holdPending = 1'b0;
        vectors++;
        if (sent != 8 || recvCount != 8) begin
            miscompares++;
            $display("[TB] FAIL stream_count: got sent=%0d received=%0d, expected 8 and 8", sent, recvCount);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b1;
        c_x = 2'b00; s_x = 8'b10101010; c_y = 2'b00; s_y = 8'b10000001;
        in_valid = 1'b1;
        @(negedge clk);
        c_x = 2'b10; s_x = 8'b00000000; c_y = 2'b01; s_y = 8'b01010101;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_setup: got out_valid=%b, expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL in_ready_in_reset: got %b, expected 0", in_ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({out_valid, y_x, y_y, ovf_x, ovf_y} !== 15'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_outputs: got %h, expected 0", {out_valid, y_x, y_y, ovf_x, ovf_y});
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL flush_resurrect: got out_valid=%b, expected 0", out_valid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        int         idx;
        int         off;
        int         t;
        bit         acc;
        logic [31:0] ui;
        logic [31:0] ut;
        idx         = 0;
        off         = int'($urandom_range(0, 1023));
        recvCount   = 0;
        holdPending = 1'b0;
        for (int cyc = 0; cyc < 8000 && (idx < 1024 || sbQ.size() > 0); cyc++) begin
            t  = idx + off;
            ui = idx;
            ut = t;
            in_valid   = (idx < 1024) && ($urandom_range(0, 3) != 0);
            {c_x, s_x} = ui[9:0];
            {c_y, s_y} = ut[9:0];
            out_ready  = ($urandom_range(0, 3) != 0);
            cycle(acc);
            if (acc) idx++;
        end
        in_valid    = 1'b0;
        holdPending = 1'b0;
        vectors++;
        if (idx != 1024 || recvCount != 1024) begin
            miscompares++;
            $display("[TB] FAIL exhaustive_count: got sent=%0d received=%0d, expected 1024 and 1024", idx, recvCount);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_reset_flush();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
